// File: rtl/booth_mult_param_if.sv
// Handshake and operand bundle for booth_mult_param.
// master: host side that drives start/operands. slave: the multiplier.
interface booth_mult_param_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  busy, done, result
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output busy, done, result
  );
endinterface

// File: rtl/booth_mult_param.sv
// Parametrised sequential Booth multiplier with a start/busy/done handshake.
// Handles signed or unsigned operands, selected at runtime per operation.
// BOOTH_RADIX4_EN defined  : radix-4 recoding, WIDTH/2+1 iterations.
// BOOTH_RADIX4_EN undefined: radix-2 recoding, WIDTH+1 iterations.
module booth_mult_param #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  booth_mult_param_if.slave bus
);

`ifdef BOOTH_RADIX4_EN
  localparam int N    = WIDTH + 2;
  localparam int ITER = N / 2;
`else
  localparam int N    = WIDTH + 1;
  localparam int ITER = N;
`endif
  localparam int CW = $clog2(ITER + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nx;
  logic [N:0]     a;
  logic [N-1:0]   q;
  logic [N-1:0]   m;
  logic           qm1;
  logic [CW-1:0]  cnt;
  logic [PW-1:0]  res_q;

  logic [N:0]     m_x, addend, a_sum, a_nx;
  logic [N-1:0]   q_nx;
  logic           qm1_nx;
  logic [PW-1:0]  prod_lo;
  logic           last;
  logic           busy_c, done_c;
  logic           ext_m, ext_q;

  assign ext_m   = bus.signed_mode & bus.multiplicand[WIDTH-1];
  assign ext_q   = bus.signed_mode & bus.multiplier[WIDTH-1];
  assign last    = (cnt == CW'(1));
  assign prod_lo = PW'({a_nx, q_nx});

  // One Booth step: recode the low multiplier bits, add to A, shift {A,Q,q_m1}.
  always_comb begin
    m_x    = {m[N-1], m};
    addend = '0;
`ifdef BOOTH_RADIX4_EN
    case ({q[1:0], qm1})
      3'b001, 3'b010: addend = m_x;
      3'b011:         addend = {m, 1'b0};
      3'b100:         addend = -{m, 1'b0};
      3'b101, 3'b110: addend = -m_x;
      default:        addend = '0;
    endcase
    a_sum  = a + addend;
    a_nx   = {{2{a_sum[N]}}, a_sum[N:2]};
    q_nx   = {a_sum[1:0], q[N-1:2]};
    qm1_nx = q[1];
`else
    case ({q[0], qm1})
      2'b01:   addend = m_x;
      2'b10:   addend = -m_x;
      default: addend = '0;
    endcase
    a_sum  = a + addend;
    a_nx   = {a_sum[N], a_sum[N:1]};
    q_nx   = {a_sum[0], q[N-1:1]};
    qm1_nx = q[0];
`endif
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx = state;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nx = CALC;
      CALC: begin
        busy_c = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done_c   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a     <= '0;
      q     <= '0;
      m     <= '0;
      qm1   <= 1'b0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          m   <= {{(N-WIDTH){ext_m}}, bus.multiplicand};
          q   <= {{(N-WIDTH){ext_q}}, bus.multiplier};
          a   <= '0;
          qm1 <= 1'b0;
          cnt <= CW'(ITER);
        end
        CALC: begin
          a   <= a_nx;
          q   <= q_nx;
          qm1 <= qm1_nx;
          cnt <= cnt - CW'(1);
          if (last) res_q <= prod_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.result = res_q;

endmodule

// File: tb/tb_booth_mult_param.sv
// Self-checking bench for booth_mult_param: directed table at WIDTH=16,
// handshake corner sequences, then randomized back-to-back streams at
// WIDTH=8, 16 and 32 compared against a plain-arithmetic product model.
module tb_booth_mult_param;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  booth_mult_param_if #(.WIDTH(8))  i8  ();
  booth_mult_param_if #(.WIDTH(16)) i16 ();
  booth_mult_param_if #(.WIDTH(32)) i32 ();

  booth_mult_param #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8));
  booth_mult_param #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(i16));
  booth_mult_param #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(i32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int iter_of(input int w);
`ifdef BOOTH_RADIX4_EN
    return w / 2 + 1;
`else
    return w + 1;
`endif
  endfunction

  // Reference: exact integer product of the extended operands, low 2w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic sm,
                                          input logic [31:0] m, input logic [31:0] q);
    longint      a, b;
    logic [63:0] p, msk;
    a = longint'({32'b0, m});
    b = longint'({32'b0, q});
    if (sm && m[w-1]) a = a - (longint'(1) << w);
    if (sm && q[w-1]) b = b - (longint'(1) << w);
    p   = a * b;
    msk = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    return p & msk;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_in(input int lane, input logic st, input logic sm,
                        input logic [31:0] m, input logic [31:0] q);
    case (lane)
      0: begin i8.start = st;  i8.signed_mode = sm;  i8.multiplicand = m[7:0];   i8.multiplier = q[7:0];   end
      1: begin i16.start = st; i16.signed_mode = sm; i16.multiplicand = m[15:0]; i16.multiplier = q[15:0]; end
      default: begin i32.start = st; i32.signed_mode = sm; i32.multiplicand = m; i32.multiplier = q; end
    endcase
  endtask

  task automatic get_out(input int lane, output logic busy, output logic done, output logic [63:0] res);
    case (lane)
      0: begin busy = i8.busy;  done = i8.done;  res = {48'b0, i8.result};  end
      1: begin busy = i16.busy; done = i16.done; res = {32'b0, i16.result}; end
      default: begin busy = i32.busy; done = i32.done; res = i32.result; end
    endcase
  endtask

  // Single WIDTH=16 operation; entered and left #1 after an edge, in IDLE.
  task automatic do_op16(input logic sm, input logic [15:0] m, input logic [15:0] q,
                         output logic [31:0] res, output int lat, output int busy_err);
    i16.signed_mode = sm; i16.multiplicand = m; i16.multiplier = q; i16.start = 1'b1;
    @(posedge clk); #1;
    i16.start = 1'b0;
    i16.multiplicand = 16'($urandom); i16.multiplier = 16'($urandom); i16.signed_mode = ~sm;
    lat = 0; busy_err = 0;
    while (!i16.done && lat < 200) begin
      if (!i16.busy) busy_err++;
      @(posedge clk); #1;
      lat++;
    end
    if (i16.busy) busy_err++;
    res = i16.result;
    @(posedge clk); #1;
  endtask

  // Start held high: one operation accepted every ITER+2 cycles.
  task automatic run_lane(input int lane, input int w, input int nv);
    int          it;
    logic        sm, busy, done;
    logic [31:0] m, q, msk;
    logic [63:0] exp, res;
    it  = iter_of(w);
    msk = (w == 32) ? '1 : ((32'd1 << w) - 32'd1);
    for (int v = 0; v < nv; v++) begin
      sm = 1'($urandom_range(0, 1));
      m  = $urandom & msk;
      q  = $urandom & msk;
      case (v % 8)
        0: m = msk;
        1: begin m = 32'd1 << (w - 1); q = 32'd1 << (w - 1); end
        2: q = (32'd1 << (w - 1)) - 32'd1;
        3: q = '0;
        default: ;
      endcase
      exp = ref_mul(w, sm, m, q);
      set_in(lane, 1'b1, sm, m, q);
      @(posedge clk); #1;
      set_in(lane, 1'b1, ~sm, $urandom, $urandom);
      repeat (it) @(posedge clk);
      #1;
      get_out(lane, busy, done, res);
      chk($sformatf("lane%0d_done", w), {63'b0, done}, 64'd1);
      chk($sformatf("lane%0d_result sm=%0d m=%h q=%h", w, sm, m, q), res, exp);
      @(posedge clk); #1;
      get_out(lane, busy, done, res);
      chk($sformatf("lane%0d_idle", w), {62'b0, busy, done}, 64'd0);
    end
    set_in(lane, 1'b0, 1'b0, '0, '0);
  endtask

  typedef struct {
    logic        sm;
    logic [15:0] m;
    logic [15:0] q;
    logic [31:0] exp;
  } vec_t;

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[11];
    logic [31:0] res;
    int          lat, berr, it16, dn, derr, rerr;
    total = 0;
    bad   = 0;
    it16  = iter_of(16);
    tbl[0]  = '{1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB};
    tbl[1]  = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    tbl[2]  = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
    tbl[3]  = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
    tbl[4]  = '{1'b1, 16'h8000, 16'h7FFF, 32'hC0008000};
    tbl[5]  = '{1'b0, 16'h8000, 16'h8000, 32'h40000000};
    tbl[6]  = '{1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    tbl[7]  = '{1'b0, 16'hFFFF, 16'h0001, 32'h0000FFFF};
    tbl[8]  = '{1'b1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF};
    tbl[9]  = '{1'b1, 16'h0000, 16'h8000, 32'h00000000};
    tbl[10] = '{1'b0, 16'h1234, 16'h0010, 32'h00012340};

    rst = 1'b1;
    set_in(0, 1'b0, 1'b0, '0, '0);
    set_in(1, 1'b0, 1'b0, '0, '0);
    set_in(2, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   {63'b0, i16.busy}, 64'd0);
    chk("reset_done",   {63'b0, i16.done}, 64'd0);
    chk("reset_result", {32'b0, i16.result}, 64'd0);
    chk("reset_result32", i32.result, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      do_op16(tbl[i].sm, tbl[i].m, tbl[i].q, res, lat, berr);
      chk($sformatf("vec%0d_result", i), {32'b0, res}, {32'b0, tbl[i].exp});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(it16));
      chk($sformatf("vec%0d_busy", i), 64'(berr), 64'd0);
    end

    // start re-pulsed while busy and on the done cycle must be ignored
    i16.signed_mode = 1'b1; i16.multiplicand = 16'hFFFD; i16.multiplier = 16'h0007; i16.start = 1'b1;
    @(posedge clk); #1;
    i16.start = 1'b0;
    dn = 0; derr = 0; rerr = 0; berr = 0;
    for (int j = 1; j <= 2 * it16 + 6; j++) begin
      if (j == 3 || j == it16 + 1) begin
        i16.start = 1'b1; i16.signed_mode = 1'b0;
        i16.multiplicand = 16'h0105; i16.multiplier = 16'h0203;
      end
      @(posedge clk); #1;
      i16.start = 1'b0;
      if (i16.busy !== (j < it16)) berr++;
      if (i16.done !== (j == it16)) derr++;
      if (i16.done === 1'b1) dn++;
      if (j >= it16 && i16.result !== 32'hFFFFFFEB) rerr++;
    end
    chk("ignore_done_count", 64'(dn), 64'd1);
    chk("ignore_done_timing", 64'(derr), 64'd0);
    chk("ignore_busy_pattern", 64'(berr), 64'd0);
    chk("ignore_result_held", 64'(rerr), 64'd0);

    // asynchronous abort three cycles into CALC
    i16.signed_mode = 1'b0; i16.multiplicand = 16'h00FF; i16.multiplier = 16'h0101; i16.start = 1'b1;
    @(posedge clk); #1;
    i16.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy",   {63'b0, i16.busy}, 64'd0);
    chk("abort_done",   {63'b0, i16.done}, 64'd0);
    chk("abort_result", {32'b0, i16.result}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op16(1'b0, 16'h00FF, 16'h0101, res, lat, berr);
    chk("after_abort_result", {32'b0, res}, 64'h0000FFFF);
    chk("after_abort_latency", 64'(lat), 64'(it16));

    fork
      run_lane(0, 8, 1500);
      run_lane(1, 16, 1500);
      run_lane(2, 32, 1500);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
